// File: rtl/huc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huc_bus_pkg
//  Description : Shared bus-cycle states and bank/IO map constants for the
//                HuC6280 memory front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package huc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DATA   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } bus_state_t;

    localparam logic [7:0] c_ROM_LAST_BANK  = 8'hF7;
    localparam logic [7:0] c_RAM_FIRST_BANK = 8'hF8;
    localparam logic [7:0] c_RAM_LAST_BANK  = 8'hFB;
    localparam logic [7:0] c_IO_BANK        = 8'hFF;

    // IO page offset bits [12:10]
    localparam logic [2:0] c_IO_VDC   = 3'b000;
    localparam logic [2:0] c_IO_VCE   = 3'b001;
    localparam logic [2:0] c_IO_PSG   = 3'b010;
    localparam logic [2:0] c_IO_TIMER = 3'b011;
    localparam logic [2:0] c_IO_JOY   = 3'b100;

    localparam logic [7:0] c_OPEN_BUS = 8'hFF;

endpackage : huc_bus_pkg
`default_nettype wire

// File: rtl/mpr_file.sv
`default_nettype none
// ============================================================================
//  Module      : mpr_file
//  Description : Eight 8-bit MPR bank registers with TAM write, TMA OR-read
//                and combinational bank lookup for the current logical page.
//  Revision    : 1.0 - initial release
// ============================================================================
module mpr_file (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mpr_we,
    input  logic [7:0] mpr_mask,
    input  logic [7:0] mpr_wdata,
    input  logic [7:0] mpr_sel,
    input  logic [2:0] page,
    output logic [7:0] mpr_rdata,
    output logic [7:0] bank
);

    logic [7:0] r_mpr [8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_mpr[i] <= 8'h00;
        end else if (mpr_we) begin
            for (int i = 0; i < 8; i++)
                if (mpr_mask[i]) r_mpr[i] <= mpr_wdata;
        end
    end

    always_comb begin
        mpr_rdata = 8'h00;
        for (int i = 0; i < 8; i++)
            if (mpr_sel[i]) mpr_rdata = mpr_rdata | r_mpr[i];
    end

    // Reads the pre-write value, so a same-cycle TAM never affects translation
    assign bank = r_mpr[page];

endmodule : mpr_file
`default_nettype wire

// File: rtl/huc6280_mmu.sv
`default_nettype none
// ============================================================================
//  Module      : huc6280_mmu
//  Description : HuC6280 bus front end: MPR address translation, chip-enable
//                decode and handshaked bus cycle with VDC/VCE wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module huc6280_mmu
    import huc_bus_pkg::*;
#(
    parameter logic [7:0] RAM_FIRST_BANK = c_RAM_FIRST_BANK,
    parameter logic [7:0] RAM_LAST_BANK  = c_RAM_LAST_BANK,
    parameter logic [7:0] IO_BANK        = c_IO_BANK,
    parameter logic [7:0] OPEN_BUS       = c_OPEN_BUS,
    parameter int         SLOW_WAIT      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        high_speed,
    input  logic        mpr_we,
    input  logic [7:0]  mpr_mask,
    input  logic [7:0]  mpr_wdata,
    input  logic [7:0]  mpr_sel,
    output logic [7:0]  mpr_rdata,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_re,
    output logic        mem_we,
    output logic        ce_n,
    output logic        cer_n,
    output logic        vdc_n,
    output logic        vce_n
);

    bus_state_t r_state, w_next;
    logic [7:0] w_bank;
    logic       w_is_rom, w_is_ram, w_is_io, w_is_vdc, w_is_vce, w_mapped, w_slow;
    logic       r_rom, r_ram, r_vdc, r_vce, r_mapped, r_we, r_slow;
    logic [2:0] r_wait_cnt;
    logic [20:0] r_mem_addr;
    logic [7:0]  r_mem_dout, r_cpu_rdata;

    mpr_file u_mpr (
        .clk       (clk),
        .rst_n     (rst_n),
        .mpr_we    (mpr_we),
        .mpr_mask  (mpr_mask),
        .mpr_wdata (mpr_wdata),
        .mpr_sel   (mpr_sel),
        .page      (cpu_addr[15:13]),
        .mpr_rdata (mpr_rdata),
        .bank      (w_bank)
    );

    always_comb begin
        w_is_rom = (w_bank <= c_ROM_LAST_BANK);
        w_is_ram = (w_bank >= RAM_FIRST_BANK) && (w_bank <= RAM_LAST_BANK);
        w_is_io  = (w_bank == IO_BANK);
        w_is_vdc = w_is_io && (cpu_addr[12:10] == c_IO_VDC);
        w_is_vce = w_is_io && (cpu_addr[12:10] == c_IO_VCE);
        w_mapped = w_is_rom || w_is_ram || w_is_io;
        w_slow   = (w_is_vdc || w_is_vce) && high_speed && (SLOW_WAIT > 0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (cpu_req && !cpu_ack) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_DATA;
            ST_DATA:   w_next = r_slow ? ST_WAIT : ST_DONE;
            ST_WAIT:   if (r_wait_cnt <= 3'd1) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rom       <= 1'b0;
            r_ram       <= 1'b0;
            r_vdc       <= 1'b0;
            r_vce       <= 1'b0;
            r_mapped    <= 1'b0;
            r_we        <= 1'b0;
            r_slow      <= 1'b0;
            r_wait_cnt  <= 3'd0;
            r_mem_addr  <= 21'd0;
            r_mem_dout  <= 8'h00;
            r_cpu_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_next == ST_ACCESS) begin
                r_rom      <= w_is_rom;
                r_ram      <= w_is_ram;
                r_vdc      <= w_is_vdc;
                r_vce      <= w_is_vce;
                r_mapped   <= w_mapped;
                r_we       <= cpu_we;
                r_slow     <= w_slow;
                r_mem_addr <= {w_bank, cpu_addr[12:0]};
                r_mem_dout <= cpu_wdata;
            end
            if (r_state == ST_DATA) begin
                if (!r_we) r_cpu_rdata <= r_mapped ? mem_din : OPEN_BUS;
                if (r_slow) r_wait_cnt <= 3'(SLOW_WAIT);
            end
            if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt - 3'd1;
        end
    end

    // Strobes and enables exist only in ACCESS, so each access is seen once
    assign mem_re    = (r_state == ST_ACCESS) && r_mapped && !r_we;
    assign mem_we    = (r_state == ST_ACCESS) && r_mapped && r_we;
    assign ce_n      = !((r_state == ST_ACCESS) && r_rom);
    assign cer_n     = !((r_state == ST_ACCESS) && r_ram);
    assign vdc_n     = !((r_state == ST_ACCESS) && r_vdc);
    assign vce_n     = !((r_state == ST_ACCESS) && r_vce);
    assign cpu_ack   = (r_state == ST_DONE);
    assign mem_addr  = r_mem_addr;
    assign mem_dout  = r_mem_dout;
    assign cpu_rdata = r_cpu_rdata;

endmodule : huc6280_mmu
`default_nettype wire

// File: tb/tb_huc6280_mmu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huc6280_mmu
//  Description : Table-driven bench for huc6280_mmu with a one-cycle memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huc6280_mmu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, high_speed = 1'b0, mpr_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00, mpr_mask = 8'h00, mpr_wdata = 8'h00, mpr_sel = 8'h00;
    logic [7:0]  cpu_rdata, mpr_rdata, mem_dout;
    logic [7:0]  mem_din = 8'h00;
    logic [20:0] mem_addr;
    logic        cpu_ack, mem_re, mem_we, ce_n, cer_n, vdc_n, vce_n;

    int n_checks = 0;
    int n_fail   = 0;

    huc6280_mmu dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .high_speed(high_speed), .mpr_we(mpr_we),
        .mpr_mask(mpr_mask), .mpr_wdata(mpr_wdata), .mpr_sel(mpr_sel),
        .mpr_rdata(mpr_rdata), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we), .ce_n(ce_n),
        .cer_n(cer_n), .vdc_n(vdc_n), .vce_n(vce_n)
    );

    always #5 clk = ~clk;

    // Physical memory with registered read data; fixed contents loaded in reset
    logic [7:0] mem_model [0:2097151];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_din <= 8'h00;
            mem_model[21'h000123] <= 8'hA5;
            mem_model[21'h000124] <= 8'hB6;
            mem_model[21'h1F0124] <= 8'hC7;
            mem_model[21'h1FE000] <= 8'h3C;
            mem_model[21'h1FE402] <= 8'h77;
            mem_model[21'h1FE800] <= 8'h99;
            mem_model[21'h1EE010] <= 8'h5C;
            mem_model[21'h1F6001] <= 8'h6D;
        end else begin
            if (mem_we) mem_model[mem_addr] <= mem_dout;
            if (mem_re) mem_din <= mem_model[mem_addr];
        end
    end

    typedef struct {
        logic [7:0]  tam_mask;
        logic [7:0]  tam_data;
        bit          tam_same;
        logic [15:0] addr;
        bit          we;
        logic [7:0]  wdata;
        bit          hs;
        logic [20:0] e_addr;
        logic [3:0]  e_en;     // {ce_n, cer_n, vdc_n, vce_n} during ACCESS
        logic [1:0]  e_strb;   // {mem_re, mem_we} during ACCESS
        logic [7:0]  e_rdata;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        int         lat;
        int         strobes;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];

    function automatic vec_t mk(logic [7:0] tm, logic [7:0] td, bit ts,
                                logic [15:0] a, bit w, logic [7:0] wd, bit hs,
                                logic [20:0] ea, logic [3:0] en, logic [1:0] st,
                                logic [7:0] rd, int lat);
        vec_t v;
        v.tam_mask = tm; v.tam_data = td; v.tam_same = ts;
        v.addr = a; v.we = w; v.wdata = wd; v.hs = hs;
        v.e_addr = ea; v.e_en = en; v.e_strb = st; v.e_rdata = rd; v.e_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   cyc;
        int   strobes;
        bit   done;
        if (v.tam_mask != 8'h00 && !v.tam_same) begin
            mpr_mask = v.tam_mask; mpr_wdata = v.tam_data; mpr_we = 1'b1;
            @(negedge clk);
            mpr_we = 1'b0;
        end
        cpu_addr = v.addr; cpu_we = v.we; cpu_wdata = v.wdata;
        high_speed = v.hs; cpu_req = 1'b1;
        if (v.tam_same) begin
            mpr_mask = v.tam_mask; mpr_wdata = v.tam_data; mpr_we = 1'b1;
        end
        e.rdata = v.e_rdata; e.lat = v.e_lat; e.strobes = (v.e_strb != 2'b00) ? 1 : 0;
        sb.push_back(e);
        cyc = 0; strobes = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            mpr_we = 1'b0;
            if (mem_re || mem_we) strobes++;
            if (cyc == 1) begin
                chk($sformatf("v%0d_addr", idx), 32'(mem_addr), 32'(v.e_addr));
                chk($sformatf("v%0d_en", idx), 32'({ce_n, cer_n, vdc_n, vce_n}), 32'(v.e_en));
                chk($sformatf("v%0d_strb", idx), 32'({mem_re, mem_we}), 32'(v.e_strb));
                if (v.we) chk($sformatf("v%0d_dout", idx), 32'(mem_dout), 32'(v.wdata));
            end
            if (cyc == 2)
                chk($sformatf("v%0d_bus_idle", idx),
                    32'({ce_n, cer_n, vdc_n, vce_n, mem_re, mem_we}), 32'(6'b111100));
            if (cpu_ack) begin
                e = sb.pop_front();
                chk($sformatf("v%0d_rdata", idx), 32'(cpu_rdata), 32'(e.rdata));
                chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(e.lat));
                chk($sformatf("v%0d_strobes", idx), 32'(strobes), 32'(e.strobes));
                done = 1'b1;
                cpu_req = 1'b0;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d_timeout: got no ack, expected ack within 20 cycles", idx);
            cpu_req = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", idx), 32'(cpu_ack), 32'(0));
    endtask

    initial begin
        bit ack_seen;
        //            mask   data  same addr     we wdata hs  e_addr        en       strb   rdata lat
        vecs[0]  = mk(8'h00, 8'h00, 0, 16'hE123, 0, 8'h00, 0, 21'h000123, 4'b0111, 2'b10, 8'hA5, 3);
        vecs[1]  = mk(8'h80, 8'hF8, 1, 16'hE124, 0, 8'h00, 0, 21'h000124, 4'b0111, 2'b10, 8'hB6, 3);
        vecs[2]  = mk(8'h00, 8'h00, 0, 16'hE124, 0, 8'h00, 0, 21'h1F0124, 4'b1011, 2'b10, 8'hC7, 3);
        vecs[3]  = mk(8'h02, 8'hF8, 0, 16'h2005, 1, 8'h5A, 0, 21'h1F0005, 4'b1011, 2'b01, 8'hC7, 3);
        vecs[4]  = mk(8'h00, 8'h00, 0, 16'h2005, 0, 8'h00, 0, 21'h1F0005, 4'b1011, 2'b10, 8'h5A, 3);
        vecs[5]  = mk(8'h01, 8'hFF, 0, 16'h0000, 0, 8'h00, 1, 21'h1FE000, 4'b1101, 2'b10, 8'h3C, 4);
        vecs[6]  = mk(8'h00, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 21'h1FE000, 4'b1101, 2'b10, 8'h3C, 3);
        vecs[7]  = mk(8'h00, 8'h00, 0, 16'h0402, 0, 8'h00, 1, 21'h1FE402, 4'b1110, 2'b10, 8'h77, 4);
        vecs[8]  = mk(8'h00, 8'h00, 0, 16'h0800, 0, 8'h00, 1, 21'h1FE800, 4'b1111, 2'b10, 8'h99, 3);
        vecs[9]  = mk(8'h00, 8'h00, 0, 16'h0C00, 1, 8'h44, 1, 21'h1FEC00, 4'b1111, 2'b01, 8'h99, 3);
        vecs[10] = mk(8'h08, 8'hFC, 0, 16'h6000, 0, 8'h00, 0, 21'h1F8000, 4'b1111, 2'b00, 8'hFF, 3);
        vecs[11] = mk(8'h00, 8'h00, 0, 16'h6001, 1, 8'h11, 0, 21'h1F8001, 4'b1111, 2'b00, 8'hFF, 3);
        vecs[12] = mk(8'h04, 8'hF7, 0, 16'h4010, 0, 8'h00, 0, 21'h1EE010, 4'b0111, 2'b10, 8'h5C, 3);
        vecs[13] = mk(8'h10, 8'hFB, 0, 16'h8001, 0, 8'h00, 0, 21'h1F6001, 4'b1011, 2'b10, 8'h6D, 3);
        vecs[14] = mk(8'h20, 8'hFE, 0, 16'hA000, 0, 8'h00, 0, 21'h1FC000, 4'b1111, 2'b00, 8'hFF, 3);
        vecs[15] = mk(8'h00, 8'h00, 0, 16'h0001, 1, 8'h02, 1, 21'h1FE001, 4'b1101, 2'b01, 8'hFF, 4);
        vecs[16] = mk(8'h00, 8'h00, 0, 16'hE123, 0, 8'h00, 0, 21'h000123, 4'b0111, 2'b10, 8'hA5, 3);

        repeat (3) @(negedge clk);
        mpr_sel = 8'hFF;
        chk("reset_ctrl", 32'({mem_re, mem_we, ce_n, cer_n, vdc_n, vce_n, cpu_ack}), 32'(7'b0011110));
        chk("reset_addr", 32'(mem_addr), 32'(0));
        chk("reset_dout", 32'(mem_dout), 32'(0));
        chk("reset_rdata", 32'(cpu_rdata), 32'(0));
        chk("reset_mpr", 32'(mpr_rdata), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // TMA OR-read across selected MPRs
        mpr_mask = 8'hFF; mpr_wdata = 8'h12; mpr_we = 1'b1;
        @(negedge clk);
        mpr_we = 1'b0; mpr_sel = 8'h80;
        #1 chk("tma_all", 32'(mpr_rdata), 32'(8'h12));
        mpr_mask = 8'h01; mpr_wdata = 8'h01; mpr_we = 1'b1;
        @(negedge clk);
        mpr_mask = 8'h02; mpr_wdata = 8'h10;
        @(negedge clk);
        mpr_we = 1'b0; mpr_sel = 8'h03;
        #1 chk("tma_or", 32'(mpr_rdata), 32'(8'h11));
        mpr_sel = 8'h00;
        #1 chk("tma_none", 32'(mpr_rdata), 32'(8'h00));

        // Reset during ACCESS drops the access
        @(negedge clk);
        cpu_addr = 16'hE123; cpu_we = 1'b0; high_speed = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        chk("rst_pre_re", 32'(mem_re), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_re_low", 32'({mem_re, cpu_ack}), 32'(0));
        cpu_req = 1'b0; rst_n = 1'b1;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack) ack_seen = 1'b1;
        end
        chk("rst_no_ack", 32'(ack_seen), 32'(0));
        mpr_sel = 8'hFF;
        #1 chk("rst_mpr_clear", 32'(mpr_rdata), 32'(0));
        chk("rst_rdata", 32'(cpu_rdata), 32'(0));
        @(negedge clk);
        run_vec(vecs[16], 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_huc6280_mmu
`default_nettype wire

// File: doc/huc6280_mmu.md
Name: huc6280_mmu

Overview:
Bus front end between the HuC6280 CPU core and the physical memory/IO model. It translates the 16-bit logical address through the eight MPR bank registers (TAM/TMA) into a 21-bit physical address. It decodes the chip enables (ROM CE_n, RAM CER_n, VDC, VCE) and runs a handshaked bus cycle against a memory whose read data is registered, with one-cycle latency. It inserts wait cycles for VDC/VCE accesses in high-speed mode.

Parameters:
RAM_FIRST_BANK, 8'hF8, first bank decoded to cer_n
RAM_LAST_BANK, 8'hFB, last bank decoded to cer_n
IO_BANK, 8'hFF, hardware I/O page
OPEN_BUS, 8'hFF, read data returned for unmapped banks
SLOW_WAIT, 1, extra cycles for VDC/VCE access when high_speed=1 (0..7)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  bus cycle request, held high until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  16  logical address
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data, registered, held until next read completes
cpu_ack  out  1  one-cycle completion pulse
high_speed  in  1  CSH state (7.16 MHz mode)
mpr_we  in  1  TAM strobe
mpr_mask  in  8  TAM operand; bit i selects MPRi
mpr_wdata  in  8  value written to selected MPRs
mpr_sel  in  8  TMA operand
mpr_rdata  out  8  OR of all MPRs selected by mpr_sel (combinational); 0 if mpr_sel=0
mem_addr  out  21  physical address
mem_dout  out  8  write data to memory
mem_din  in  8  read data from memory (valid the cycle after mem_re)
mem_re  out  1  read strobe
mem_we  out  1  write strobe
ce_n  out  1  ROM enable, banks 00..F7
cer_n  out  1  RAM enable, banks RAM_FIRST..RAM_LAST
vdc_n  out  1  bank IO_BANK, offset 0000-03FF
vce_n  out  1  bank IO_BANK, offset 0400-07FF

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; MPR0..7=8'h00; mem_re=mem_we=0; all enables=1; mem_addr=0; mem_dout=0; cpu_rdata=8'h00; cpu_ack=0; wait counter=0.
- Translation: bank=MPR[cpu_addr[15:13]]; mem_addr={bank,cpu_addr[12:0]}. The result is latched on the IDLE->ACCESS edge and is unaffected by later MPR writes.
- Decode: bank<=F7 -> ce_n; RAM range -> cer_n; IO_BANK with offset[12:10]=000 -> vdc_n, 001 -> vce_n. Other IO offsets: no enable asserted, strobes still issued (PSG/timer/joypad decode by address downstream). Banks between RAM_LAST+1 and IO_BANK-1: no enable, no strobe; reads return OPEN_BUS.
- State machine: IDLE, ACCESS, DATA, WAIT, DONE.
  - IDLE: on cpu_req=1 (and cpu_ack=0), latch address/data/decode; go to ACCESS.
  - ACCESS: exactly one cycle. mem_re=~cpu_we and mem_we=cpu_we, both gated by "mapped"; enables active.
  - DATA: strobes low, enables high; cpu_rdata<=mem_din for mapped reads, OPEN_BUS for unmapped reads, unchanged for writes. If the access was VDC/VCE, high_speed=1 and SLOW_WAIT>0, load counter=SLOW_WAIT and go to WAIT; otherwise go to DONE.
  - WAIT: decrement the counter; go to DONE when it reaches 1.
  - DONE: cpu_ack=1 for this cycle only; go to IDLE. IDLE ignores cpu_req during the ack cycle, so no double issue.
- Latency: with cpu_req sampled at edge 0, mem_re is high in cycle 1, cpu_rdata is valid and cpu_ack high in cycle 3. Slow VDC/VCE accesses take 3+SLOW_WAIT cycles.
- Strobes never repeat within one cycle, so VDC status-read side effects happen once.
- high_speed is sampled at the IDLE->ACCESS edge.
- TAM: on mpr_we, every MPRi with mpr_mask[i]=1 gets mpr_wdata, visible from the next cycle. A TAM write in the same cycle as an IDLE request does not affect that request's translation (old value used).
- Reset mid-cycle: immediate return to IDLE; outputs take reset values; the pending access is dropped with no ack.

Decomposition:
- Package huc_bus_pkg:
  - bus state enum
  - bank constants (ROM_LAST_BANK=F7, RAM_FIRST/LAST, IO_BANK)
  - IO offset ranges (VDC 000, VCE 001, PSG 010, TIMER 011, JOY 100)
  - OPEN_BUS
- Sub-module mpr_file: the 8x8 register array, TAM write port, TMA OR-read port, and combinational bank lookup by cpu_addr[15:13].

Test Plan:
1. Reset, then read 0xE123 -> mem_addr=21'h00123, ce_n=0 and mem_re=1 in cycle 1 only; memory returns 0xA5; cpu_rdata=0xA5 and cpu_ack=1 in cycle 3.
2. TAM mask=0x02 data=0xF8; write 0x2005 data 0x5A -> mem_addr=21'h1F0005, cer_n=0, ce_n=1, mem_we one cycle, mem_dout=0x5A. Reading 0x2005 back -> 0x5A.
3. TAM mask=0x01 data=0xFF. With high_speed=1, read 0x0000 -> vdc_n=0, one mem_re pulse, ack in cycle 4. With high_speed=0 -> ack in cycle 3. Read 0x0402 -> vce_n=0.
4. MPR3=0xFC; read 0x6000 -> no strobes, all enables high, cpu_rdata=0xFF, ack in cycle 3.
5. TAM mask=0xFF data=0x12, then TMA sel=0x80 -> 0x12. Set MPR0=0x01, MPR1=0x10; TMA sel=0x03 -> 0x11.
6. rst_n=0 during ACCESS of a read -> next cycle mem_re=0, no cpu_ack ever, MPRs=0x00. A new request after reset completes normally.
